// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Requester indices; the encoding doubles as the round-robin pointer value.
  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_MD = 1'b1
  } req_e;

  localparam int NUM_REQ = 2;

  // Register 0 is hardwired; writes to it are swallowed at the buffer.
  localparam int ZERO_REG = 0;

endpackage

// File: rtl/wr_hold_buffer.sv
// One-entry valid/ready holding buffer for a single register-file writer.
// Writes to register 0 are accepted but never stored.
module wr_hold_buffer
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  drain,
  output logic                  ready,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_data
);

  logic accept;

  // Ready comes straight from the full flop, so there is no path from valid.
  assign ready  = !full;
  assign accept = valid && ready && (addr != ADDR_WIDTH'(ZERO_REG));

  // Occupancy flag: drain and accept never coincide because ready=0 while full.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    if (reset) begin
      full <= 1'b0;
    end else if (drain) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end
  end

  // Payload capture on a stored transfer.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; it is only observed while full
    // is set, and full is cleared by reset.
    if (accept) begin
      buf_addr <= addr;
      buf_data <= data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// writeback stage (WB) and the multiply/divide unit (MD).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  md_valid,
  input  logic [ADDR_WIDTH-1:0] md_addr,
  input  logic [DATA_WIDTH-1:0] md_data,
  output logic                  md_ready,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic                  busy
);

  logic                  wb_full, md_full;
  logic [ADDR_WIDTH-1:0] wb_buf_addr, md_buf_addr;
  logic [DATA_WIDTH-1:0] wb_buf_data, md_buf_data;
  logic                  grant_wb, grant_md;
  req_e                  last_grant;

  wr_hold_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wb_buf (
    .clk      (clk),
    .reset    (reset),
    .valid    (wb_valid),
    .addr     (wb_addr),
    .data     (wb_data),
    .drain    (grant_wb),
    .ready    (wb_ready),
    .full     (wb_full),
    .buf_addr (wb_buf_addr),
    .buf_data (wb_buf_data)
  );

  wr_hold_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_md_buf (
    .clk      (clk),
    .reset    (reset),
    .valid    (md_valid),
    .addr     (md_addr),
    .data     (md_data),
    .drain    (grant_md),
    .ready    (md_ready),
    .full     (md_full),
    .buf_addr (md_buf_addr),
    .buf_data (md_buf_data)
  );

  // Grant selection: a lone full buffer wins; on contention the requester
  // that was not granted last wins.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants and no latch forms.
    grant_wb = 1'b0;
    grant_md = 1'b0;
    if (wb_full && md_full) begin
      grant_wb = (last_grant == REQ_MD);
      grant_md = (last_grant == REQ_WB);
    end else begin
      grant_wb = wb_full;
      grant_md = md_full;
    end
  end

  // Registered write port and round-robin pointer; reset overrides any grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      last_grant       <= REQ_MD;
    end else begin
      ctrl_writeEnable <= grant_wb || grant_md;
      if (grant_wb) begin
        ctrl_writeReg <= wb_buf_addr;
        data_writeReg <= wb_buf_data;
        last_grant    <= REQ_WB;
      end else if (grant_md) begin
        ctrl_writeReg <= md_buf_addr;
        data_writeReg <= md_buf_data;
        last_grant    <= REQ_MD;
      end
    end
  end

  assign busy = wb_full || md_full || ctrl_writeEnable;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, md_valid;
  logic [4:0]  wb_addr, md_addr;
  logic [31:0] wb_data, md_data;
  logic        wb_ready, md_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .wb_ready         (wb_ready),
    .md_valid         (md_valid),
    .md_addr          (md_addr),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int wb_idx, md_idx, write_n;
    logic wb_acc, md_acc;
    logic exp_md;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;

    reset = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_wb_ready", wb_ready, 1);
    check("rst_md_ready", md_ready, 1);
    check("rst_we", ctrl_writeEnable, 0);
    check("rst_reg", ctrl_writeReg, 0);
    check("rst_data", data_writeReg, 0);
    check("rst_busy", busy, 0);

    // Single WB write: addr 5, 0xDEADBEEF
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    wb_valid = 1'b0;
    check("t1_wb_ready_low", wb_ready, 0);
    check("t1_we_e", ctrl_writeEnable, 0);
    check("t1_busy_e", busy, 1);
    step();
    check("t1_we", ctrl_writeEnable, 1);
    check("t1_reg", ctrl_writeReg, 5);
    check("t1_data", data_writeReg, 32'hDEADBEEF);
    check("t1_wb_ready_back", wb_ready, 1);
    step();
    check("t1_we_drop", ctrl_writeEnable, 0);
    check("t1_busy_idle", busy, 0);
    check("t1_reg_hold", ctrl_writeReg, 5);
    check("t1_data_hold", data_writeReg, 32'hDEADBEEF);

    // Simultaneous WB/MD after reset: WB first, then MD
    do_reset();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h22;
    step();
    wb_valid = 1'b0; md_valid = 1'b0;
    check("t2_wb_full", wb_ready, 0);
    check("t2_md_full", md_ready, 0);
    step();
    check("t2_we0", ctrl_writeEnable, 1);
    check("t2_reg0", ctrl_writeReg, 3);
    check("t2_data0", data_writeReg, 32'h11);
    check("t2_md_waits", md_ready, 0);
    step();
    check("t2_we1", ctrl_writeEnable, 1);
    check("t2_reg1", ctrl_writeReg, 4);
    check("t2_data1", data_writeReg, 32'h22);
    step();
    check("t2_we_drop", ctrl_writeEnable, 0);
    check("t2_busy_idle", busy, 0);

    // Continuous valid from both for 10 edges: writes alternate WB, MD
    do_reset();
    wb_idx = 0; md_idx = 0; write_n = 0;
    for (int c = 0; c < 10; c++) begin
      wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h1000 + wb_idx;
      md_valid = 1'b1; md_addr = 5'd20; md_data = 32'h2000 + md_idx;
      wb_acc = wb_ready;
      md_acc = md_ready;
      step();
      if (wb_acc) wb_idx++;
      if (md_acc) md_idx++;
      if (c >= 1) begin
        exp_md   = write_n[0];
        exp_addr = exp_md ? 5'd20 : 5'd10;
        exp_data = (exp_md ? 32'h2000 : 32'h1000) + (write_n / 2);
        check("t3_we", ctrl_writeEnable, 1);
        check("t3_reg", ctrl_writeReg, exp_addr);
        check("t3_data", data_writeReg, exp_data);
        write_n++;
      end
    end
    wb_valid = 1'b0; md_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ctrl_writeEnable) begin
        exp_md   = write_n[0];
        exp_addr = exp_md ? 5'd20 : 5'd10;
        exp_data = (exp_md ? 32'h2000 : 32'h1000) + (write_n / 2);
        check("t3_drain_reg", ctrl_writeReg, exp_addr);
        check("t3_drain_data", data_writeReg, exp_data);
        write_n++;
      end
    end
    check("t3_write_count", write_n, 10);
    check("t3_no_loss", write_n, wb_idx + md_idx);
    check("t3_busy_idle", busy, 0);

    // MD write to register 0 is swallowed
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hFFFF;
    step();
    check("t4_md_ready", md_ready, 1);
    check("t4_busy", busy, 0);
    check("t4_we", ctrl_writeEnable, 0);
    step();
    md_valid = 1'b0;
    check("t4_md_ready2", md_ready, 1);
    check("t4_busy2", busy, 0);
    step();
    check("t4_we_late", ctrl_writeEnable, 0);
    check("t4_busy_late", busy, 0);

    // Both buffers full, then reset for one edge
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hA7;
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'hB9;
    step();
    wb_valid = 1'b0; md_valid = 1'b0;
    check("t5_busy_full", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_we", ctrl_writeEnable, 0);
    check("t5_wb_ready", wb_ready, 1);
    check("t5_md_ready", md_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_reg", ctrl_writeReg, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t5_no_stale", ctrl_writeEnable, 0);
    end

    // WB held valid while full: MD wins the contention, WB write lands once
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h0101;
    step();
    wb_valid = 1'b0;
    step();
    check("t6_pre_we", ctrl_writeEnable, 1);
    check("t6_pre_reg", ctrl_writeReg, 1);
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0C0;
    md_valid = 1'b1; md_addr = 5'd13; md_data = 32'hD0D0;
    step();
    md_valid = 1'b0;
    check("t6_wb_blocked", wb_ready, 0);
    step();
    check("t6_md_first_we", ctrl_writeEnable, 1);
    check("t6_md_first_reg", ctrl_writeReg, 13);
    check("t6_md_first_data", data_writeReg, 32'hD0D0);
    check("t6_wb_still_full", wb_ready, 0);
    step();
    check("t6_wb_we", ctrl_writeEnable, 1);
    check("t6_wb_reg", ctrl_writeReg, 12);
    check("t6_wb_data", data_writeReg, 32'hC0C0);
    check("t6_wb_ready", wb_ready, 1);
    wb_valid = 1'b0;
    step();
    check("t6_no_dup", ctrl_writeEnable, 0);
    step();
    check("t6_no_dup2", ctrl_writeEnable, 0);
    check("t6_busy_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
